// File: rtl/reg_writeback.sv
// Writeback merge of single-cycle ALU results and buffered load results onto the
// register file write port, with a pending-load scoreboard and load anti-starvation.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module reg_writeback #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_alu_valid,
  output logic                         o_alu_ready,
  input  logic [$clog2(`NUM_REGS)-1:0] i_alu_rd,
  input  logic [`XLEN-1:0]             i_alu_data,
  input  logic                         i_issue_valid,
  input  logic [$clog2(`NUM_REGS)-1:0] i_issue_rd,
  input  logic                         i_lsu_valid,
  output logic                         o_lsu_ready,
  input  logic [$clog2(`NUM_REGS)-1:0] i_lsu_rd,
  input  logic [`XLEN-1:0]             i_lsu_data,
  output logic                         o_we,
  output logic [$clog2(`NUM_REGS)-1:0] o_waddr,
  output logic [`XLEN-1:0]             o_wdata,
  output logic [`NUM_REGS-1:0]         o_pending
);

  localparam int RW = $clog2(`NUM_REGS);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  logic [RW-1:0]     fifo_rd   [DEPTH];
  logic [`XLEN-1:0]  fifo_data [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [3:0]        starve_cnt;

  logic              empty, full, force_load, alu_win, pop, push;
  logic [RW-1:0]     head_rd;
  logic [`XLEN-1:0]  head_data;
  logic [3:0]        starve_nxt;
  logic [`NUM_REGS-1:0] pending_nxt;

  // The extra pointer bit tells a full ring from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign force_load  = (starve_cnt == STARVE_LIM) && !empty;
  assign o_alu_ready = !force_load;
  assign o_lsu_ready = !full;
  assign alu_win     = i_alu_valid && !force_load;
  assign pop         = !alu_win && !empty;
  // Loads to x0 complete the handshake but never occupy a slot.
  assign push        = i_lsu_valid && !full && (i_lsu_rd != '0);

  assign head_rd   = fifo_rd[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    starve_nxt = starve_cnt;
    if (pop || empty)
      starve_nxt = '0;
    else if (alu_win && (starve_cnt != STARVE_LIM))
      starve_nxt = starve_cnt + 4'd1;
  end

  // Issue is applied after the pop clear so a same-cycle set wins.
  always_comb begin
    pending_nxt = o_pending;
    if (pop)
      pending_nxt[head_rd] = 1'b0;
    if (i_issue_valid)
      pending_nxt[i_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone say which slots are valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd[wr_ptr[AW-1:0]]   <= i_lsu_rd;
      fifo_data[wr_ptr[AW-1:0]] <= i_lsu_data;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      o_pending  <= '0;
      o_we       <= 1'b0;
      o_waddr    <= '0;
      o_wdata    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      starve_cnt <= starve_nxt;
      o_pending  <= pending_nxt;
      if (alu_win) begin
        o_we    <= (i_alu_rd != '0);
        o_waddr <= i_alu_rd;
        o_wdata <= i_alu_data;
      end else if (pop) begin
        o_we    <= 1'b1;
        o_waddr <= head_rd;
        o_wdata <= head_data;
      end else begin
        o_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_reg_writeback;

  localparam int NR    = `NUM_REGS;
  localparam int RW    = $clog2(NR);
  localparam int XL    = `XLEN;
  localparam int DEPTH = 4;
  localparam int SM    = 3;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          alu_valid, issue_valid, lsu_valid;
  logic [RW-1:0] alu_rd, issue_rd, lsu_rd;
  logic [XL-1:0] alu_data, lsu_data;

  logic          alu_ready, lsu_ready, we;
  logic [RW-1:0] waddr;
  logic [XL-1:0] wdata;
  logic [NR-1:0] pending;

  logic          f_alu_ready, f_lsu_ready, f_we;
  logic [RW-1:0] f_waddr;
  logic [XL-1:0] f_wdata;
  logic [NR-1:0] f_pending;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  reg_writeback #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata), .o_pending(pending)
  );

  // Second instance with a long starvation limit, used for the FIFO-full sequence.
  reg_writeback #(.DEPTH(DEPTH), .STARVE_MAX(15)) dut15 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_valid(alu_valid), .o_alu_ready(f_alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(f_lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
    .o_we(f_we), .o_waddr(f_waddr), .o_wdata(f_wdata), .o_pending(f_pending)
  );

  typedef struct {
    logic          v;
    logic [RW-1:0] rd;
    logic [XL-1:0] data;
    logic          ewe;
    logic [RW-1:0] eaddr;
    logic [XL-1:0] edata;
  } alu_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic do_reset();
    idle();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset_state();
    do_reset();
    check("rst_we",        64'(we), 64'(0));
    check("rst_waddr",     64'(waddr), 64'(0));
    check("rst_wdata",     64'(wdata), 64'(0));
    check("rst_pending",   64'(pending), 64'(0));
    check("rst_lsu_ready", 64'(lsu_ready), 64'(1));
    check("rst_alu_ready", 64'(alu_ready), 64'(1));
  endtask

  task automatic test_alu_table();
    alu_vec_t vecs[6];
    vecs[0] = '{1'b1, RW'(5),  XL'(32'h1234_5678), 1'b1, RW'(5),  XL'(32'h1234_5678)};
    vecs[1] = '{1'b1, RW'(31), XL'(32'hFFFF_FFFF), 1'b1, RW'(31), XL'(32'hFFFF_FFFF)};
    vecs[2] = '{1'b0, RW'(6),  XL'(32'h0000_0055), 1'b0, RW'(0),  XL'(0)};
    vecs[3] = '{1'b1, RW'(0),  XL'(32'h0000_ABCD), 1'b0, RW'(0),  XL'(0)};
    vecs[4] = '{1'b1, RW'(1),  XL'(32'h0000_0000), 1'b1, RW'(1),  XL'(0)};
    vecs[5] = '{1'b1, RW'(16), XL'(32'h8000_0000), 1'b1, RW'(16), XL'(32'h8000_0000)};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alu_valid = vecs[i].v; alu_rd = vecs[i].rd; alu_data = vecs[i].data;
      check("tbl_alu_ready", 64'(alu_ready), 64'(1));
      step();
      check("tbl_we", 64'(we), 64'(vecs[i].ewe));
      if (vecs[i].ewe) begin
        check("tbl_waddr", 64'(waddr), 64'(vecs[i].eaddr));
        check("tbl_wdata", 64'(wdata), 64'(vecs[i].edata));
      end
    end
    idle();
  endtask

  task automatic test_load_path();
    do_reset();
    issue_valid = 1'b1; issue_rd = RW'(7);
    step();
    check("ld_pend_set", 64'(pending[7]), 64'(1));
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = RW'(7); lsu_data = XL'(32'hDEAD_BEEF);
    check("ld_lsu_ready", 64'(lsu_ready), 64'(1));
    step();
    lsu_valid = 1'b0;
    check("ld_no_early_we", 64'(we), 64'(0));
    check("ld_pend_held", 64'(pending[7]), 64'(1));
    step();
    check("ld_we",    64'(we), 64'(1));
    check("ld_waddr", 64'(waddr), 64'(7));
    check("ld_wdata", 64'(wdata), 64'(32'hDEAD_BEEF));
    check("ld_pend_clr", 64'(pending[7]), 64'(0));
    step();
    check("ld_we_after", 64'(we), 64'(0));
  endtask

  task automatic test_starvation();
    logic          exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [RW-1:0] exp_a   [6] = '{RW'(10), RW'(11), RW'(12), RW'(13), RW'(3), RW'(14)};
    logic [XL-1:0] exp_d   [6] = '{XL'('hA0), XL'('hA1), XL'('hA2), XL'('hA3), XL'('h33), XL'('hA4)};
    int k = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = RW'(10 + k); alu_data = XL'(32'hA0 + k);
      lsu_valid = (c == 0); lsu_rd = RW'(3); lsu_data = XL'(32'h33);
      check("stv_alu_ready", 64'(alu_ready), 64'(exp_rdy[c]));
      if (exp_rdy[c]) k++;
      step();
      check("stv_we",    64'(we), 64'(1));
      check("stv_waddr", 64'(waddr), 64'(exp_a[c]));
      check("stv_wdata", 64'(wdata), 64'(exp_d[c]));
    end
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    alu_valid = 1'b1; alu_rd = '0; alu_data = XL'(32'h77);
    lsu_valid = 1'b1; lsu_rd = '0; lsu_data = XL'(32'h88);
    check("x0_alu_ready", 64'(alu_ready), 64'(1));
    check("x0_lsu_ready", 64'(lsu_ready), 64'(1));
    step();
    idle();
    check("x0_we", 64'(we), 64'(0));
    check("x0_pend0", 64'(pending[0]), 64'(0));
    step();
    check("x0_no_pop_we", 64'(we), 64'(0));
    check("x0_lsu_ready_after", 64'(lsu_ready), 64'(1));
  endtask

  task automatic test_set_wins();
    do_reset();
    issue_valid = 1'b1; issue_rd = RW'(9);
    step();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = RW'(9); lsu_data = XL'(32'h99);
    step();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = RW'(9);
    step();
    issue_valid = 1'b0;
    check("sw_we",    64'(we), 64'(1));
    check("sw_waddr", 64'(waddr), 64'(9));
    check("sw_pend",  64'(pending[9]), 64'(1));
    step();
    check("sw_pend_hold", 64'(pending[9]), 64'(1));
  endtask

  task automatic test_fifo_full();
    logic [RW+XL-1:0] seen[$];
    bit acc5 = 1'b0;
    bit took;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      alu_valid = 1'b1; alu_rd = RW'(20); alu_data = XL'(c);
      lsu_valid = 1'b1;
      lsu_rd   = (c < 4) ? RW'(c + 1) : RW'(5);
      lsu_data = (c < 4) ? XL'(32'h100 + c + 1) : XL'(32'h105);
      check("full_lsu_ready", 64'(f_lsu_ready), 64'(c < 4));
      step();
    end
    for (int k = 0; k < 30 && seen.size() < 5; k++) begin
      alu_valid = 1'b0;
      lsu_valid = !acc5; lsu_rd = RW'(5); lsu_data = XL'(32'h105);
      took = lsu_valid && f_lsu_ready;
      step();
      if (took) acc5 = 1'b1;
      if (f_we) seen.push_back({f_waddr, f_wdata});
    end
    idle();
    check("full_drain_count", 64'(seen.size()), 64'(5));
    for (int i = 0; i < seen.size() && i < 5; i++)
      check("full_drain_entry", 64'(seen[i]), 64'({RW'(i + 1), XL'(32'h100 + i + 1)}));
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = RW'(21); alu_data = XL'(c);
      issue_valid = 1'b1; issue_rd = RW'(11 + c);
      lsu_valid = 1'b1; lsu_rd = RW'(11 + c); lsu_data = XL'(32'h200 + c);
      step();
    end
    issue_valid = 1'b0; lsu_valid = 1'b0;
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    idle();
    check("rmid_pending",   64'(pending), 64'(0));
    check("rmid_we",        64'(we), 64'(0));
    check("rmid_lsu_ready", 64'(lsu_ready), 64'(1));
    check("rmid_alu_ready", 64'(alu_ready), 64'(1));
    alu_valid = 1'b1; alu_rd = RW'(5); alu_data = XL'(32'h11);
    step();
    idle();
    check("rmid_we1",    64'(we), 64'(1));
    check("rmid_waddr",  64'(waddr), 64'(5));
    check("rmid_wdata",  64'(wdata), 64'(32'h11));
    step();
    check("rmid_no_stale", 64'(we), 64'(0));
  endtask

  // Reference model: the FIFO is a pair of queues, the scoreboard a bit vector,
  // outstanding loads a list of registers still waiting for their data.
  task automatic run_random(input int cycles);
    logic [RW-1:0] q_rd[$];
    logic [XL-1:0] q_data[$];
    logic [RW-1:0] outst[$];
    logic [NR-1:0] m_pend = '0;
    int            cnt = 0;
    bit            hold = 1'b0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      bit            frc, win, pop, exp_we;
      logic [RW-1:0] exp_addr;
      logic [XL-1:0] exp_data;
      int            sz, r, idx;
      if (!hold) begin
        alu_valid = ($urandom_range(0, 9) < 7);
        alu_rd    = ($urandom_range(0, 15) == 0) ? '0 : RW'($urandom_range(1, NR - 1));
        alu_data  = XL'($urandom);
      end
      issue_valid = 1'b0; issue_rd = '0;
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, NR - 1);
        if (!m_pend[r]) begin
          issue_valid = 1'b1; issue_rd = RW'(r);
          check("rnd_issue_not_pending", 64'(pending[r]), 64'(0));
        end
      end
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = XL'($urandom); idx = -1;
      if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, outst.size() - 1);
        lsu_valid = 1'b1; lsu_rd = outst[idx];
      end else if ($urandom_range(0, 19) == 0) begin
        lsu_valid = 1'b1;
      end
      sz  = q_rd.size();
      frc = (cnt == SM) && (sz > 0);
      check("rnd_alu_ready", 64'(alu_ready), 64'(!frc));
      check("rnd_lsu_ready", 64'(lsu_ready), 64'(sz < DEPTH));
      win = alu_valid && !frc;
      pop = !win && (sz > 0);
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      if (win) begin
        exp_we = (alu_rd != '0); exp_addr = alu_rd; exp_data = alu_data;
      end else if (pop) begin
        exp_we = 1'b1; exp_addr = q_rd[0]; exp_data = q_data[0];
        m_pend[q_rd[0]] = 1'b0;
        q_rd.delete(0);
        q_data.delete(0);
      end
      if (lsu_valid && sz < DEPTH && lsu_rd != '0) begin
        q_rd.push_back(lsu_rd);
        q_data.push_back(lsu_data);
        outst.delete(idx);
      end
      if (issue_valid && issue_rd != '0) begin
        m_pend[issue_rd] = 1'b1;
        outst.push_back(issue_rd);
      end
      if (pop || sz == 0) cnt = 0;
      else if (cnt < SM)  cnt++;
      hold = alu_valid && !win;
      step();
      check("rnd_we", 64'(we), 64'(exp_we));
      if (exp_we) begin
        check("rnd_waddr", 64'(waddr), 64'(exp_addr));
        check("rnd_wdata", 64'(wdata), 64'(exp_data));
      end
      check("rnd_pending", 64'(pending), 64'(m_pend));
    end
    idle();
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    step();
    test_reset_state();
    test_alu_table();
    test_load_path();
    test_starvation();
    test_x0();
    test_set_wins();
    test_fifo_full();
    test_reset_mid();
    run_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage directly upstream of the register file's write port. It merges single-cycle ALU results and out-of-order load results from the LSU onto the register file's single write port (`i_we`/`i_waddr`/`i_wdata`). It buffers load results in a small FIFO and keeps a per-register pending-load scoreboard so decode can stall on RAW and WAW hazards. It also enforces anti-starvation so that loads cannot be blocked indefinitely by back-to-back ALU writes.

## Interface
Parameters:
- DEPTH, 4, load-result FIFO entries; power of two, ≥2
- STARVE_MAX, 3, consecutive cycles in which the ALU may win while the FIFO is non-empty before one load is forced through; range 1..15

Ports:
- i_clk  in  1  clock; all state updates on posedge
- i_rst  in  1  synchronous, active-high reset
- i_alu_valid  in  1  ALU result present
- o_alu_ready  out  1  ALU result accepted this cycle; when low, ALU must hold rd/data stable
- i_alu_rd  in  $clog2(`NUM_REGS)  ALU destination
- i_alu_data  in  `XLEN  ALU result
- i_issue_valid  in  1  a load is being issued this cycle; marks its rd pending
- i_issue_rd  in  $clog2(`NUM_REGS)  issued load's destination
- i_lsu_valid  in  1  load result present
- o_lsu_ready  out  1  FIFO can accept; equals !full
- i_lsu_rd  in  $clog2(`NUM_REGS)  load destination
- i_lsu_data  in  `XLEN  load data
- o_we  out  1  register file write enable (registered)
- o_waddr  out  $clog2(`NUM_REGS)  register file write address (registered)
- o_wdata  out  `XLEN  register file write data (registered)
- o_pending  out  `NUM_REGS  bit r high means an issued load to xr has not yet been written back (registered)

## Operation
- **LSU push:** on i_lsu_valid && o_lsu_ready.
  - If i_lsu_rd == 0, accept and discard: no enqueue, and o_pending is unaffected.
  - Otherwise enqueue {rd, data}.
  - There is no push while full, even if a pop occurs in the same cycle.
- **Arbitration, each cycle:**
  - force = (starve_cnt == STARVE_MAX) && fifo non-empty.
  - o_alu_ready = !force.
  - ALU wins when i_alu_valid && !force.
  - Otherwise the FIFO head is popped when the FIFO is non-empty.
- **ALU write:** an ALU win with i_alu_rd == 0 still consumes the ALU handshake but produces o_we = 0. The FIFO does not pop in that cycle.
- **starve_cnt (4-bit):**
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears on any FIFO pop, or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- **Scoreboard:**
  - Set bit i_issue_rd on i_issue_valid with rd ≠ 0.
  - Clear bit rd when a FIFO pop of that rd is driven to the write port.
  - Set and clear of the same bit in the same cycle results in 1 (set wins).
  - Bit 0 is always 0.
  - Decode guarantees it never issues a load to a register whose pending bit is set; the bench asserts this.
- **FIFO:** read/write pointers are $clog2(DEPTH)+1 bits wide so that full and empty are distinguishable; pointers wrap modulo 2·DEPTH.

## Timing
- **Reset values:**
  - o_we = 0, o_waddr = 0, o_wdata = 0, o_pending = 0.
  - FIFO empty (o_lsu_ready = 1), starve_cnt = 0, so o_alu_ready = 1.
- **Reset mid-operation:** FIFO contents and pending bits are discarded. o_we = 0 in the first cycle after reset is deasserted.
- **Latency:**
  - Selected source at cycle N → o_we/o_waddr/o_wdata valid in cycle N+1. The register file commits at the end of N+1.
  - Pending clear becomes visible in cycle N+1, together with o_we.
- **Throughput:** one write per cycle; the FIFO drains at one entry per cycle when the ALU is idle.
- **Combinational paths:**
  - o_alu_ready depends only on registered state: starve_cnt and FIFO occupancy.
  - o_lsu_ready depends only on occupancy.
- **Push visibility:** an entry pushed in cycle N can be popped at the earliest in cycle N+1.

## Test plan
- **Reset:** i_rst high for 2 cycles mid-stream with 3 entries queued → o_pending = 0, o_we = 0, o_lsu_ready = 1, o_alu_ready = 1. A subsequent ALU write {x5, 0x11} appears on o_we/o_waddr/o_wdata one cycle later.
- **Load path:** issue x7, then an LSU result {x7, 0xDEADBEEF} with the ALU idle → o_pending[7] = 1 from the cycle after issue. The write {x7, 0xDEADBEEF} appears 1 cycle after the push is popped, and o_pending[7] = 0 in the same cycle.
- **FIFO full:** push DEPTH=4 loads while the ALU is valid every cycle and STARVE_MAX = 15 → o_lsu_ready = 0 after the 4th push. The 5th push is held until a pop, and no entry is lost or duplicated.
- **Starvation:** FIFO holds {x3, 0x33} and the ALU is valid every cycle with STARVE_MAX = 3 → 3 ALU writes, then o_alu_ready = 0 for exactly one cycle and x3 = 0x33 is written. The held ALU result is written next.
- **x0 handling:** ALU rd = 0 and LSU rd = 0 → both handshakes complete, o_we stays 0, o_pending[0] stays 0, and the FIFO count is unchanged.
- **Scoreboard set-wins:** issue x9 in the same cycle as the popped write of an earlier x9 load → o_pending[9] = 1 afterward.
